regfile_32x64: RTL and testbench



---
 rtl/cpu_regfile_pkg.sv | 13 +
 rtl/decoder_5to32.sv | 17 +
 rtl/regfile_32x64.sv | 70 +++++++
 tb/tb_regfile_32x64.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_regfile_pkg.sv
// Shared constants and types for the architectural integer register file.
package cpu_regfile_pkg;

    localparam int REG_WIDTH  = 64;
    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_WIDTH-1:0]  reg_data_t;

    localparam reg_addr_t XZR_IDX = 5'd31;

endpackage

// File: rtl/decoder_5to32.sv
// Write-back address decoder: turns enable + 5-bit index into a one-hot enable vector.
module decoder_5to32
    import cpu_regfile_pkg::*;
(
    input  logic        en,
    input  reg_addr_t   addr,
    output logic [31:0] en_onehot
);

    always_comb begin
        en_onehot = '0;
        if (en) begin
            en_onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_32x64.sv
// 31 x WIDTH general-purpose registers plus hardwired-zero XZR, one write and two read ports.
// Optional same-cycle write-to-read bypass is compiled in with REGFILE_BYPASS_EN.
module regfile_32x64
    import cpu_regfile_pkg::*;
#(
    parameter int WIDTH    = REG_WIDTH,
    parameter int NUM_REGS = cpu_regfile_pkg::NUM_REGS,
    parameter int ADDR_W   = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [WIDTH-1:0]  write_data,
    input  logic [ADDR_W-1:0] read_addr1,
    input  logic [ADDR_W-1:0] read_addr2,
    output logic [WIDTH-1:0]  read_data1,
    output logic [WIDTH-1:0]  read_data2
);

    localparam logic [ADDR_W-1:0] XZR = ADDR_W'(NUM_REGS - 1);

    logic [NUM_REGS-2:0] reg_we;
    logic                dec_unused_xzr;
    logic [WIDTH-1:0]    mux_in [NUM_REGS];

    decoder_5to32 u_decoder (
        .en        (write_enable),
        .addr      (write_addr),
        .en_onehot ({dec_unused_xzr, reg_we})
    );

    // XZR has no storage; its mux leg is a constant zero.
    assign mux_in[NUM_REGS-1] = '0;

    for (genvar i = 0; i < NUM_REGS - 1; i++) begin : g_reg
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                mux_in[i] <= '0;
            end else if (reg_we[i]) begin
                mux_in[i] <= write_data;
            end
        end
    end

    logic [WIDTH-1:0] stored1;
    logic [WIDTH-1:0] stored2;

    assign stored1 = mux_in[read_addr1];
    assign stored2 = mux_in[read_addr2];

`ifdef REGFILE_BYPASS_EN
    // Forwarding is gated by reset_n so outputs stay zero while reset is held.
    logic fwd1;
    logic fwd2;

    assign fwd1 = reset_n && write_enable && (write_addr == read_addr1) && (write_addr != XZR);
    assign fwd2 = reset_n && write_enable && (write_addr == read_addr2) && (write_addr != XZR);

    assign read_data1 = fwd1 ? write_data : stored1;
    assign read_data2 = fwd2 ? write_data : stored2;
`else
    logic xzr_unused;

    assign xzr_unused = ^XZR;
    assign read_data1 = stored1;
    assign read_data2 = stored2;
`endif

endmodule

// File: tb/tb_regfile_32x64.sv
// Directed bench for regfile_32x64; expectations follow REGFILE_BYPASS_EN when defined.
module tb_regfile_32x64;

    logic        clk;
    logic        reset_n;
    logic        write_enable;
    logic [4:0]  write_addr;
    logic [63:0] write_data;
    logic [4:0]  read_addr1;
    logic [4:0]  read_addr2;
    logic [63:0] read_data1;
    logic [63:0] read_data2;

    int vectors;
    int miscompares;

    regfile_32x64 dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .read_addr1   (read_addr1),
        .read_addr2   (read_addr2),
        .read_data1   (read_data1),
        .read_data2   (read_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [63:0] d);
        @(negedge clk);
        write_enable = 1'b1;
        write_addr   = a;
        write_data   = d;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        reset_n      = 1'b0;
        write_enable = 1'b0;
        write_addr   = '0;
        write_data   = '0;
        read_addr1   = '0;
        read_addr2   = '0;

        // Reset held: sweep both ports, and a write attempted during reset is ignored.
        write_enable = 1'b1;
        write_addr   = 5'd3;
        write_data   = 64'hFACE;
        for (int i = 0; i < 32; i++) begin
            read_addr1 = 5'(i);
            read_addr2 = 5'(31 - i);
            #1;
            check($sformatf("rst_rd1_%0d", i), read_data1, 64'h0);
            check($sformatf("rst_rd2_%0d", i), read_data2, 64'h0);
        end
        @(posedge clk);
        #1;
        read_addr1 = 5'd3;
        #1;
        check("rst_write_ignored", read_data1, 64'h0);
        write_enable = 1'b0;

        // Asynchronous release between edges.
        @(negedge clk);
        #2;
        reset_n    = 1'b1;
        read_addr1 = 5'd5;
        #1;
        check("post_rst_x5", read_data1, 64'h0);

        // Basic write then read.
        write_reg(5'd3, 64'hDEAD_BEEF_0123_4567);
        read_addr1 = 5'd3;
        read_addr2 = 5'd4;
        #1;
        check("basic_x3", read_data1, 64'hDEAD_BEEF_0123_4567);
        check("basic_x4", read_data2, 64'h0);

        // Fill X0..X30 with i*0x0101.
        for (int i = 0; i < 31; i++) begin
            write_reg(5'(i), 64'(i) * 64'h0101);
        end

        // XZR write is dropped.
        write_reg(5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
        read_addr1 = 5'd31;
        read_addr2 = 5'd31;
        #1;
        check("xzr_rd1", read_data1, 64'h0);
        check("xzr_rd2", read_data2, 64'h0);
        for (int i = 0; i < 31; i++) begin
            read_addr1 = 5'(i);
            read_addr2 = 5'(30 - i);
            #1;
            check($sformatf("sweep_rd1_%0d", i), read_data1, 64'(i) * 64'h0101);
            check($sformatf("sweep_rd2_%0d", i), read_data2, 64'(30 - i) * 64'h0101);
        end

        // XZR read with a write to 31 pending in the same cycle.
        @(negedge clk);
        write_enable = 1'b1;
        write_addr   = 5'd31;
        write_data   = 64'h1234;
        read_addr1   = 5'd31;
        #1;
        check("xzr_pending", read_data1, 64'h0);
        @(posedge clk);
        #1;
        write_enable = 1'b0;

        // write_enable low with write_data toggling: nothing changes.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            write_addr = 5'(i * 7);
            write_data = (i % 2 == 0) ? 64'hAAAA_AAAA_AAAA_AAAA : 64'h5555_5555_5555_5555;
        end
        read_addr1 = 5'd0;  read_addr2 = 5'd30; #1;
        check("pair_0", read_data1, 64'h0);
        check("pair_30", read_data2, 64'h1E1E);
        read_addr1 = 5'd15; read_addr2 = 5'd15; #1;
        check("pair_15a", read_data1, 64'hF0F);
        check("pair_15b", read_data2, 64'hF0F);
        read_addr1 = 5'd30; read_addr2 = 5'd31; #1;
        check("pair_30b", read_data1, 64'h1E1E);
        check("pair_31", read_data2, 64'h0);

        // Same-cycle write and read of X7.
        write_reg(5'd7, 64'h11);
        @(negedge clk);
        write_enable = 1'b1;
        write_addr   = 5'd7;
        write_data   = 64'h22;
        read_addr1   = 5'd7;
        read_addr2   = 5'd8;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("hazard_same", read_data1, 64'h22);
`else
        check("hazard_same", read_data1, 64'h11);
`endif
        check("hazard_other", read_data2, 64'h0808);
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        check("hazard_next", read_data1, 64'h22);

        // Reset asserted between edges while a write is pending.
        write_reg(5'd10, 64'hAA);
        read_addr1 = 5'd10;
        read_addr2 = 5'd3;
        #1;
        check("x10_before", read_data1, 64'hAA);
        @(negedge clk);
        write_enable = 1'b1;
        write_addr   = 5'd10;
        write_data   = 64'h55;
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_x10", read_data1, 64'h0);
        check("midrst_x3", read_data2, 64'h0);
        @(posedge clk);
        #1;
        check("midrst_edge_x10", read_data1, 64'h0);
        write_enable = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("after_rel_x10", read_data1, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
